// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the immediate type from the opcode or an
// explicit select, and returns the sign-extended immediate through a 2-entry output buffer.
module imm_gen_pipe #(
  parameter int unsigned     XLEN          = 32,
  parameter bit              AUTO_DECODE   = 1'b1,
  parameter logic [XLEN-1:0] ILLEGAL_VALUE = 'hDEADBEEF,
  parameter int unsigned     CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       imm_type,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [2:0] {
    T_I    = 3'b000,
    T_S    = 3'b001,
    T_B    = 3'b010,
    T_U    = 3'b011,
    T_J    = 3'b100,
    T_NONE = 3'b101,
    T_ILL  = 3'b111
  } imm_kind_t;

  imm_kind_t          kind;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    new_imm;

  always_comb begin
    kind = T_ILL;
    if (AUTO_DECODE) begin
      case (instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: kind = T_I;
        7'b0100011:                                     kind = T_S;
        7'b1100011:                                     kind = T_B;
        7'b0110111, 7'b0010111:                         kind = T_U;
        7'b1101111:                                     kind = T_J;
        7'b0110011:                                     kind = T_NONE;
        default:                                        kind = T_ILL;
      endcase
    end else begin
      case (sel)
        3'b000:  kind = T_I;
        3'b001:  kind = T_S;
        3'b010:  kind = T_B;
        3'b011:  kind = T_U;
        3'b100:  kind = T_J;
        3'b101:  kind = T_NONE;
        default: kind = T_ILL;
      endcase
    end
  end

  // Every format takes its sign from instr[31]; build a signed 32-bit value and widen it.
  always_comb begin
    imm32 = '0;
    case (kind)
      T_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      T_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      T_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      T_U:     imm32 = {instr[31:12], 12'b0};
      T_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    new_imm = XLEN'(imm32);
    if (kind == T_ILL) new_imm = ILLEGAL_VALUE;
  end

  logic            sk_valid;
  logic [XLEN-1:0] sk_imm;
  logic [2:0]      sk_type;
  logic            sk_ill;
  logic            accept;
  logic            drain;

  // The skid is the only thing that can block input, so its emptiness is the ready flop.
  assign in_ready = ~sk_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign drain    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      imm           <= '0;
      imm_type      <= 3'b000;
      illegal       <= 1'b0;
      sk_valid      <= 1'b0;
      sk_imm        <= '0;
      sk_type       <= 3'b000;
      sk_ill        <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sk_valid  <= 1'b0;
    end else begin
      if (drain) begin
        if (sk_valid) begin
          imm       <= sk_imm;
          imm_type  <= sk_type;
          illegal   <= sk_ill;
          out_valid <= 1'b1;
          sk_valid  <= 1'b0;
        end else if (accept) begin
          imm       <= new_imm;
          imm_type  <= kind;
          illegal   <= (kind == T_ILL);
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!out_valid) begin
          imm       <= new_imm;
          imm_type  <= kind;
          illegal   <= (kind == T_ILL);
          out_valid <= 1'b1;
        end else begin
          sk_imm   <= new_imm;
          sk_type  <= kind;
          sk_ill   <= (kind == T_ILL);
          sk_valid <= 1'b1;
        end
      end
      if (accept && kind == T_ILL && illegal_count != '1)
        illegal_count <= illegal_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: four instances (32-bit auto, 64-bit auto,
// 2-bit counter, manual select) share stimulus and are checked against hand values.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [2:0]  sel;

  logic        rdy32, ov32, il32;
  logic [31:0] imm32;
  logic [2:0]  ty32;
  logic [7:0]  cnt32;

  logic        rdy64, ov64, il64;
  logic [63:0] imm64;
  logic [2:0]  ty64;
  logic [7:0]  cnt64;

  logic        rdyc2, ovc2, ilc2;
  logic [31:0] immc2;
  logic [2:0]  tyc2;
  logic [1:0]  cntc2;

  logic        rdym, ovm, ilm;
  logic [31:0] immm;
  logic [2:0]  tym;
  logic [7:0]  cntm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_gen_pipe u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .sel(sel), .out_valid(ov32), .out_ready(out_ready),
    .imm(imm32), .imm_type(ty32), .illegal(il32), .illegal_count(cnt32)
  );

  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .sel(sel), .out_valid(ov64), .out_ready(out_ready),
    .imm(imm64), .imm_type(ty64), .illegal(il64), .illegal_count(cnt64)
  );

  imm_gen_pipe #(.CNT_W(2)) uc2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdyc2),
    .instr(instr), .sel(sel), .out_valid(ovc2), .out_ready(out_ready),
    .imm(immc2), .imm_type(tyc2), .illegal(ilc2), .illegal_count(cntc2)
  );

  imm_gen_pipe #(.AUTO_DECODE(1'b0)) um (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdym),
    .instr(instr), .sel(sel), .out_valid(ovm), .out_ready(out_ready),
    .imm(immm), .imm_type(tym), .illegal(ilm), .illegal_count(cntm)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; sel = 3'b000;
    #3;
    tests++; if (ov32 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", ov32); end
    tests++; if (rdy32 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", rdy32); end
    tests++; if (imm64 !== 64'h0) begin fails++; $display("FAIL reset_imm got %h want 0", imm64); end
    tests++; if (ty32 !== 3'b000 || il32 !== 1'b0 || cnt32 !== 8'd0) begin
      fails++; $display("FAIL reset_type_ill_cnt got %b/%b/%0d want 000/0/0", ty32, il32, cnt32);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_addi;
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFF00093;
    tick;
    in_valid = 1'b0;
    tests++; if (ov32 !== 1'b1) begin fails++; $display("FAIL addi_valid got %b want 1", ov32); end
    tests++; if (imm32 !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_imm got %h want ffffffff", imm32); end
    tests++; if (ty32 !== 3'b000 || il32 !== 1'b0) begin fails++; $display("FAIL addi_type got %b/%b want 000/0", ty32, il32); end
    tick;
    tests++; if (ov32 !== 1'b0) begin fails++; $display("FAIL addi_drained got %b want 0", ov32); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFE112E23;
    tick;
    tests++; if (imm32 !== 32'hFFFFFFFC || ty32 !== 3'b001 || rdy32 !== 1'b1) begin
      fails++; $display("FAIL b2b_sw got %h/%b/%b want fffffffc/001/1", imm32, ty32, rdy32);
    end
    instr = 32'hFE000CE3;
    tick;
    tests++; if (imm32 !== 32'hFFFFFFF8 || ty32 !== 3'b010 || rdy32 !== 1'b1 || ov32 !== 1'b1) begin
      fails++; $display("FAIL b2b_beq got %h/%b/%b/%b want fffffff8/010/1/1", imm32, ty32, rdy32, ov32);
    end
    instr = 32'h123450B7;
    tick;
    tests++; if (imm32 !== 32'h12345000 || ty32 !== 3'b011 || rdy32 !== 1'b1 || ov32 !== 1'b1) begin
      fails++; $display("FAIL b2b_lui got %h/%b/%b/%b want 12345000/011/1/1", imm32, ty32, rdy32, ov32);
    end
    instr = 32'h00000033;
    tick;
    tests++; if (imm32 !== 32'h0 || ty32 !== 3'b101 || il32 !== 1'b0) begin
      fails++; $display("FAIL b2b_none got %h/%b/%b want 0/101/0", imm32, ty32, il32);
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_xlen64;
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h800000B7;
    tick;
    tests++; if (imm64 !== 64'hFFFFFFFF80000000 || ty64 !== 3'b011) begin
      fails++; $display("FAIL x64_lui got %h/%b want ffffffff80000000/011", imm64, ty64);
    end
    tests++; if (imm32 !== 32'h80000000) begin fails++; $display("FAIL x32_lui got %h want 80000000", imm32); end
    instr = 32'h0000006F;
    tick;
    tests++; if (imm64 !== 64'h0 || ty64 !== 3'b100) begin
      fails++; $display("FAIL x64_jal got %h/%b want 0/100", imm64, ty64);
    end
    instr = 32'h8000006F;
    tick;
    tests++; if (imm64 !== 64'hFFFFFFFFFFF00000) begin
      fails++; $display("FAIL x64_jal_neg got %h want fffffffffff00000", imm64);
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_manual;
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFE112E23; sel = 3'b001;
    tick;
    tests++; if (immm !== 32'hFFFFFFFC || tym !== 3'b001) begin
      fails++; $display("FAIL manual_s got %h/%b want fffffffc/001", immm, tym);
    end
    sel = 3'b110;
    tick;
    tests++; if (immm !== 32'hDEADBEEF || tym !== 3'b111 || ilm !== 1'b1 || cntm !== 8'd1) begin
      fails++; $display("FAIL manual_ill got %h/%b/%b/%0d want deadbeef/111/1/1", immm, tym, ilm, cntm);
    end
    sel = 3'b000; in_valid = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093;
    tick;
    tests++; if (ov32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || rdy32 !== 1'b1) begin
      fails++; $display("FAIL bp_first got %b/%h/%b want 1/ffffffff/1", ov32, imm32, rdy32);
    end
    instr = 32'hFE112E23;
    tick;
    tests++; if (rdy32 !== 1'b0 || imm32 !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL bp_skid got %b/%h want 0/ffffffff", rdy32, imm32);
    end
    instr = 32'h123450B7;
    tick;
    tests++; if (rdy32 !== 1'b0 || imm32 !== 32'hFFFFFFFF || ov32 !== 1'b1) begin
      fails++; $display("FAIL bp_hold got %b/%h/%b want 0/ffffffff/1", rdy32, imm32, ov32);
    end
    out_ready = 1'b1;
    tick;
    tests++; if (imm32 !== 32'hFFFFFFFC || ov32 !== 1'b1 || rdy32 !== 1'b1) begin
      fails++; $display("FAIL bp_second got %h/%b/%b want fffffffc/1/1", imm32, ov32, rdy32);
    end
    tick;
    in_valid = 1'b0;
    tests++; if (imm32 !== 32'h12345000 || ov32 !== 1'b1) begin
      fails++; $display("FAIL bp_third got %h/%b want 12345000/1", imm32, ov32);
    end
    tick;
    tests++; if (ov32 !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", ov32); end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0000007F;
    tick;
    tests++; if (il32 !== 1'b1 || imm32 !== 32'hDEADBEEF || ty32 !== 3'b111 || cnt32 !== 8'd1) begin
      fails++; $display("FAIL ill_first got %b/%h/%b/%0d want 1/deadbeef/111/1", il32, imm32, ty32, cnt32);
    end
    tests++; if (imm64 !== 64'h00000000DEADBEEF) begin
      fails++; $display("FAIL ill_x64 got %h want 00000000deadbeef", imm64);
    end
    tick; tick; tick; tick;
    in_valid = 1'b0;
    tests++; if (cntc2 !== 2'd3) begin fails++; $display("FAIL ill_sat got %0d want 3", cntc2); end
    tests++; if (cnt32 !== 8'd5) begin fails++; $display("FAIL ill_count got %0d want 5", cnt32); end
    tick;
  endtask

  task automatic test_flush_reset;
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093;
    tick;
    instr = 32'hFE112E23;
    tick;
    flush = 1'b1; instr = 32'h123450B7;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (ov32 !== 1'b0 || rdy32 !== 1'b1) begin
      fails++; $display("FAIL flush_state got %b/%b want 0/1", ov32, rdy32);
    end
    out_ready = 1'b1;
    tick;
    tests++; if (ov32 !== 1'b0) begin fails++; $display("FAIL flush_no_ghost got %b want 0", ov32); end
    flush = 1'b1; in_valid = 1'b1; instr = 32'h0000007F;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (ov32 !== 1'b0 || cnt32 !== 8'd5) begin
      fails++; $display("FAIL flush_discard got %b/%0d want 0/5", ov32, cnt32);
    end
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093;
    tick; tick;
    #2;
    rst = 1'b1;
    #1;
    tests++; if (ov32 !== 1'b0 || rdy32 !== 1'b1 || imm32 !== 32'h0 || ty32 !== 3'b000 || cnt32 !== 8'd0 || cntc2 !== 2'd0) begin
      fails++; $display("FAIL async_rst got %b/%b/%h/%b/%0d/%0d want 0/1/0/000/0/0", ov32, rdy32, imm32, ty32, cnt32, cntc2);
    end
    in_valid = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_xlen64;
    test_manual;
    test_backpressure;
    test_illegal;
    test_flush_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the pipelined RV32/RV64 core's decode stage. It accepts 32-bit instructions over a valid/ready handshake and returns the sign-extended XLEN-bit immediate one cycle later. Immediate type comes from the opcode (auto mode) or an explicit select, covering I/S/B/U/J plus a no-immediate class. A 2-entry output buffer (output register plus skid) keeps in_ready fully registered, and an illegal-encoding flag and saturating counter are provided.

Parameters:
XLEN, 32, output width; legal values 32 or 64.
AUTO_DECODE, 1, 1 = type decoded from instr[6:0]; 0 = type taken from sel.
ILLEGAL_VALUE, 'hDEADBEEF, XLEN-bit value driven on imm for illegal encodings (zero-extended to XLEN).
CNT_W, 8, width of illegal_count.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous pipeline flush
in_valid  in  1  instr/sel valid
in_ready  out  1  block can accept; registered
instr  in  32  instruction word
sel  in  3  type select, used only when AUTO_DECODE=0
out_valid  out  1  imm/imm_type/illegal valid
out_ready  in  1  downstream accepts
imm  out  XLEN  sign-extended immediate
imm_type  out  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 none, 111 illegal
illegal  out  1  encoding not recognised
illegal_count  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (async, rst=1): out_valid=0, skid empty, in_ready=1, imm=0, imm_type=000, illegal=0, illegal_count=0.
- Auto decode from opcode: 0010011/0000011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> none (imm=0, legal); anything else -> illegal.
- Manual mode: sel 000-101 map to the same codes; sel 110 and 111 -> illegal.
- Immediate formation, sign bit is always instr[31], extended to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}, sign-extended to XLEN when XLEN=64.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Illegal: imm=ILLEGAL_VALUE, imm_type=111, illegal=1.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - Latency is exactly 1 cycle from input acceptance to out_valid when the output register is free.
- Buffering:
  - Accepted data goes to the output register if it is empty or being drained that cycle and the skid is empty; otherwise it goes to the skid.
  - On drain with skid full, skid moves to the output register and the skid empties.
  - in_ready(next) = skid empty after the cycle's updates.
  - Outputs are stable while out_valid && !out_ready.
  - Order is strictly FIFO; no drop, no duplication.
- Simultaneous accept and drain with skid empty: new data loads the output register with no bubble, giving sustained 1 per cycle.
- flush (sync): out_valid=0, skid empty, in_ready=1 next cycle.
  - Any same-cycle input acceptance is discarded.
  - illegal_count is not reset and does not count the discarded item.
- illegal_count increments on acceptance of an illegal item and saturates at 2^CNT_W-1.
- rst asserted mid-transfer: all state is cleared immediately; in-flight data is lost.
- in_valid while in_ready=0 is ignored; the source must hold it.

Test Plan:
- XLEN=32, auto: instr 0xFFF00093 (addi -1), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, imm_type=000.
- Back-to-back 0xFE112E23 (sw -4), 0xFE000CE3 (beq -8), 0x123450B7 (lui) -> imm 0xFFFFFFFC, 0xFFFFFFF8, 0x12345000 on consecutive cycles, in_ready held 1.
- XLEN=64: 0x800000B7 -> imm=0xFFFFFFFF80000000, imm_type=011; 0x0000006F (jal 0) -> imm=0, imm_type=100.
- out_ready=0, offer 3 instrs -> first two accepted, in_ready=0 from the cycle after the second; raise out_ready -> outputs in order, third accepted, no bubble.
- instr 0x0000007F -> illegal=1, imm=0xDEADBEEF, illegal_count 0->1; CNT_W=2 with 5 illegals -> count=3.
- Skid full, pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed item never appears; then assert rst mid-stream -> all outputs return to reset values immediately.
